// File: rtl/traffic_light_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : traffic_light_monitor                                  |
// | Description : Watches the north and east light codes of a two-way    |
// |               junction and flags conflicts, illegal codes, bad phase |
// |               order and dwell-time violations. Counts north cycles.  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module traffic_light_monitor #(
  parameter int GREEN_MIN  = 5,
  parameter int YELLOW_LEN = 2,
  parameter int TIMEOUT    = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] north_light,
  input  logic [2:0] east_light,
  output logic       conflict,
  output logic       illegal_code,
  output logic       bad_seq,
  output logic       timing_err,
  output logic       err_sticky,
  output logic [7:0] rotations
);

  localparam int DW = $clog2(TIMEOUT + 1);

  localparam logic [0:0]    c_arm     = 1'b0;
  localparam logic [0:0]    c_run     = 1'b1;
  localparam logic [2:0]    c_red     = 3'b100;
  localparam logic [2:0]    c_yel     = 3'b010;
  localparam logic [2:0]    c_grn     = 3'b001;
  localparam logic [DW-1:0] c_timeout = DW'(TIMEOUT);
  localparam logic [DW-1:0] c_one     = DW'(1);
  localparam logic [31:0]   c_grn_min = 32'(GREEN_MIN);
  localparam logic [31:0]   c_yel_len = 32'(YELLOW_LEN);

  // Index 0 is north, index 1 is east.
  logic [2:0] w_code [2];
  logic [1:0] w_ill;
  logic [1:0] w_seq;
  logic [1:0] w_tim;
  logic [1:0] w_r2g;
  logic       w_conflict;
  logic       w_any_err;

  assign w_code[0] = north_light;
  assign w_code[1] = east_light;

  for (genvar gi = 0; gi < 2; gi++) begin : g_app
    logic [0:0]    r_state;
    logic [2:0]    r_prev;
    logic [DW-1:0] r_dwell;
    logic          w_onehot;
    logic          w_same;
    logic [31:0]   w_dwell32;
    logic          w_ill_a;
    logic          w_seq_a;
    logic          w_tim_a;
    logic          w_r2g_a;

    assign w_onehot  = (w_code[gi] == c_red) || (w_code[gi] == c_yel) ||
                       (w_code[gi] == c_grn);
    assign w_same    = (w_code[gi] == r_prev);
    assign w_dwell32 = 32'(r_dwell);

    // Classify the current sample against the remembered phase.
    always_comb begin
      w_ill_a = 1'b0;
      w_seq_a = 1'b0;
      w_tim_a = 1'b0;
      w_r2g_a = 1'b0;
      if (!w_onehot) begin
        w_ill_a = 1'b1;
      end else if (r_state == c_run) begin
        if (w_same) begin
          // Fires only on the step into TIMEOUT; saturation stops repeats.
          w_tim_a = (r_dwell == c_timeout - c_one);
        end else begin
          w_seq_a = !(((r_prev == c_grn) && (w_code[gi] == c_yel)) ||
                      ((r_prev == c_yel) && (w_code[gi] == c_red)) ||
                      ((r_prev == c_red) && (w_code[gi] == c_grn)));
          w_tim_a = ((r_prev == c_grn) && (w_dwell32 < c_grn_min)) ||
                    ((r_prev == c_yel) && (w_dwell32 != c_yel_len));
          w_r2g_a = (r_prev == c_red) && (w_code[gi] == c_grn);
        end
      end
    end

    assign w_ill[gi] = w_ill_a;
    assign w_seq[gi] = w_seq_a;
    assign w_tim[gi] = w_tim_a;
    assign w_r2g[gi] = w_r2g_a;

    // Phase tracker: illegal samples leave all history untouched.
    always_ff @(posedge clk) begin
      if (reset) begin
        r_state <= c_arm;
        r_prev  <= 3'b000;
        r_dwell <= '0;
      end else if (w_onehot) begin
        if (r_state == c_arm) begin
          r_state <= c_run;
          r_prev  <= w_code[gi];
          r_dwell <= c_one;
        end else if (w_same) begin
          if (r_dwell != c_timeout) begin
            r_dwell <= r_dwell + c_one;
          end
        end else begin
          r_prev  <= w_code[gi];
          r_dwell <= c_one;
        end
      end
    end
  end

  // Any lit green or yellow bit counts as non-red; works on raw samples.
  assign w_conflict = (|north_light[1:0]) && (|east_light[1:0]);
  assign w_any_err  = w_conflict || (|w_ill) || (|w_seq) || (|w_tim);

  logic       r_conflict;
  logic       r_illegal;
  logic       r_bad_seq;
  logic       r_timing;
  logic       r_sticky;
  logic [7:0] r_rotations;

  // Register the OR of both approaches' flags, sticky error and cycle count.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_conflict  <= 1'b0;
      r_illegal   <= 1'b0;
      r_bad_seq   <= 1'b0;
      r_timing    <= 1'b0;
      r_sticky    <= 1'b0;
      r_rotations <= 8'd0;
    end else begin
      r_conflict <= w_conflict;
      r_illegal  <= |w_ill;
      r_bad_seq  <= |w_seq;
      r_timing   <= |w_tim;
      r_sticky   <= r_sticky || w_any_err;
      if (w_r2g[0]) begin
        r_rotations <= r_rotations + 8'd1;
      end
    end
  end

  assign conflict     = r_conflict;
  assign illegal_code = r_illegal;
  assign bad_seq      = r_bad_seq;
  assign timing_err   = r_timing;
  assign err_sticky   = r_sticky;
  assign rotations    = r_rotations;

endmodule
`default_nettype wire
